mem_port_arbiter: RTL

Arbitrates the single-ported unified instruction/data memory between the fetch stage and the MEM-stage load/store unit. It replaces the clock-phase multiplexing of the memory port with a clocked request/grant scheme. Data accesses win by default, and a bounded starvation counter guarantees fetch progress. A registered owner tag routes each read response back to the requester that issued it, and an explicit fetch stall goes to the PC/IF_ID load enables.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_starve_ctr.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
//
// Contents:
//   owner_t      tag of the requester owed a read response next cycle
//   FUNCT3_WORD  access size driven to memory for instruction fetches

package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating counter of consecutive blocked fetch cycles
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset, clears the count
//   i_inc     in   fetch was blocked this cycle, count up (saturates at STARVE_MAX)
//   i_clr     in   fetch made progress or is idle, count returns to 0
//   o_at_max  out  count has reached STARVE_MAX, fetch must win the next contention

module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  generate
    if (STARVE_MAX < 1) begin : g_bad_param
      $error("arb_starve_ctr: STARVE_MAX must be 1 or more");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic          w_at_max;

  assign w_at_max = (r_cnt == CW'(STARVE_MAX));
  assign o_at_max = w_at_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - request/grant arbiter for the shared I/D memory port
//
// Ports:
//   clk, reset                  clock and asynchronous active-low reset
//   if_req/if_addr              fetch read request from the PC
//   if_gnt/if_stall             fetch accepted / fetch held (PC and IF_ID enables)
//   if_rvalid/if_rdata          instruction word, one cycle after if_gnt
//   d_req/d_we/d_funct3/d_addr/d_wdata
//                               load/store request from the MEM stage
//   d_gnt                       data access accepted
//   d_rvalid/d_rdata            load data, one cycle after a load grant
//   mem_read/mem_write/mem_funct3/mem_addr/mem_wdata
//                               memory port driven by this cycle's winner
//   mem_rdata                   memory read data, valid the cycle after mem_read
//
// Data wins contention by default; after STARVE_MAX consecutive lost cycles the
// fetch is forced through so the pipeline front end always makes progress.

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  generate
    if (STARVE_MAX < 1) begin : g_bad_param
      $error("mem_port_arbiter: STARVE_MAX must be 1 or more");
    end
  endgenerate

  logic   w_at_max;
  logic   w_contend;
  logic   w_if_gnt;
  logic   w_d_gnt;
  logic   w_starve_inc;
  logic   w_starve_clr;
  owner_t r_owner;

  // ---------------------------------------------------------------------------
  // Grant decision. Gating with reset keeps every grant (and therefore every
  // memory strobe) low while the block is held in reset.
  // ---------------------------------------------------------------------------
  assign w_contend = if_req & d_req;
  assign w_if_gnt  = reset & if_req & (~d_req | w_at_max);
  assign w_d_gnt   = reset & d_req & ~w_if_gnt;

  // The counter only advances when fetch actually loses to data; any other
  // cycle (fetch granted, fetch idle) means fetch is not being starved.
  assign w_starve_inc = reset & w_contend & ~w_at_max;
  assign w_starve_clr = ~w_starve_inc;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (w_starve_inc),
    .i_clr    (w_starve_clr),
    .o_at_max (w_at_max)
  );

  assign if_gnt   = w_if_gnt;
  assign d_gnt    = w_d_gnt;
  assign if_stall = reset & if_req & ~w_if_gnt;

  // ---------------------------------------------------------------------------
  // Memory port drive from the winner; all zero when nobody is granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (w_if_gnt) begin
      mem_read   = 1'b1;
      mem_funct3 = FUNCT3_WORD;
      mem_addr   = if_addr;
    end else if (w_d_gnt) begin
      mem_read   = ~d_we;
      mem_write  = d_we;
      mem_funct3 = d_funct3;
      mem_addr   = d_addr;
      mem_wdata  = d_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Owner tag: remembers who issued last cycle's read so the response coming
  // back on mem_rdata goes to the right requester. Stores return nothing, so
  // they leave the tag at NONE. Reset drops any response still in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_NONE;
    end else begin
      if (w_if_gnt) begin
        r_owner <= OWN_IF;
      end else if (w_d_gnt && !d_we) begin
        r_owner <= OWN_DATA;
      end else begin
        r_owner <= OWN_NONE;
      end
    end
  end

  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    case (r_owner)
      OWN_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      OWN_DATA: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule
